// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, sigma/Sigma/ch/maj helpers and
// the message-scheduler state type.
package sha256_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  localparam logic [5:0] LAST_T = 6'd63;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Upper-case Sigma functions and ch/maj belong to the compression round.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                    input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_sched_next.sv
// Combinational schedule expansion: W[t+16] from the 16-word window taps.
module sha256_sched_next
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w16
);

  // Carries out of bit 31 are dropped: the sum is modulo 2^32.
  assign w16 = sigma1(w14) + w9 + sigma0(w1) + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads 16 block words, then streams W_t/K_t/t for
// the 64 compression rounds through a sliding 16-word window.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_out,
  output logic [31:0] k_out,
  output logic [5:0]  t_out,
  output logic        w_last
);

  sched_state_t state, state_nxt;
  logic [3:0]   cnt;
  logic [5:0]   t;
  logic [31:0]  r [16];
  logic [31:0]  w_new;
  logic         blk_fire;
  logic         w_fire;

  sha256_sched_next u_next (
    .w0  (r[0]),
    .w1  (r[1]),
    .w9  (r[9]),
    .w14 (r[14]),
    .w16 (w_new)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    case (state)
      LOAD: begin
        blk_ready = 1'b1;
        if (blk_valid && cnt == 4'd15) state_nxt = RUN;
      end
      RUN: begin
        w_valid = 1'b1;
        if (w_ready && t == LAST_T) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign blk_fire = blk_valid && blk_ready;
  assign w_fire   = w_valid && w_ready;

  // cnt wraps to 0 on the 16th word and t wraps to 0 on the final round, so
  // both counters are already primed for the next block without extra logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 4'd0;
      t   <= 6'd0;
      for (int i = 0; i < 16; i++) r[i] <= 32'd0;
    end else if (blk_fire) begin
      r[cnt] <= blk_word;
      cnt    <= cnt + 4'd1;
      if (cnt == 4'd15) t <= 6'd0;
    end else if (w_fire) begin
      for (int i = 0; i < 15; i++) r[i] <= r[i+1];
      r[15] <= w_new;
      t     <= t + 6'd1;
    end
  end

  assign w_out  = r[0];
  assign k_out  = K_TAB[t];
  assign t_out  = t;
  assign w_last = w_valid && (t == LAST_T);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed/randomized bench for sha256_msg_sched against a plain-arithmetic
// model of the SHA-256 message schedule.
module tb_sha256_msg_sched;

  typedef logic [31:0] block_t [16];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [31:0] blk_word = 32'd0;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_out;
  logic [31:0] k_out;
  logic [5:0]  t_out;
  logic        w_last;

  int checks = 0;
  int errors = 0;
  int transfers;
  int cycles;

  logic [31:0] exp_w  [64];
  logic [31:0] got_w  [64];
  logic [31:0] save_w [64];

  logic [31:0] k_ref [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  block_t abc_blk, zero_blk, ones_blk, rnd_blk;

  sha256_msg_sched dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_word  (blk_word),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .k_out     (k_out),
    .t_out     (t_out),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model(input block_t b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(exp_w[i-15], 7) ^ rr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = rr(exp_w[i-2], 17) ^ rr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after n accepted words.
  task automatic load_words(input block_t b, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ((maxgap > 0) ? $urandom_range(maxgap, 0) : 0) begin
        blk_valid = 1'b0;
        blk_word  = $urandom;
        @(negedge clk);
      end
      blk_valid = 1'b1;
      blk_word  = b[i];
      chk("blk_ready_load", {31'd0, blk_ready}, 32'd1);
      chk("w_valid_load", {31'd0, w_valid}, 32'd0);
      @(negedge clk);
    end
    blk_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, input bit junk, input int stop_t);
    transfers = 0;
    cycles    = 0;
    while (transfers < stop_t && cycles < 1000) begin
      chk("w_valid_run", {31'd0, w_valid}, 32'd1);
      chk("w_out", w_out, exp_w[transfers]);
      chk("k_out", k_out, k_ref[transfers]);
      chk("t_out", {26'd0, t_out}, transfers);
      chk("w_last", {31'd0, w_last}, (transfers == 63) ? 32'd1 : 32'd0);
      if (junk) begin
        chk("blk_ready_run", {31'd0, blk_ready}, 32'd0);
        blk_valid = 1'b1;
        blk_word  = $urandom;
      end else begin
        blk_valid = 1'b0;
      end
      w_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      got_w[transfers] = w_out;
      @(negedge clk);
      cycles++;
      if (w_ready) transfers++;
    end
    w_ready   = 1'b0;
    blk_valid = 1'b0;
    chk("drain_transfers", transfers, stop_t);
  endtask

  task automatic after_block();
    chk("w_valid_after", {31'd0, w_valid}, 32'd0);
    chk("blk_ready_after", {31'd0, blk_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_t_out", {26'd0, t_out}, 32'd0);
    chk("rst_k_out", k_out, 32'h428a2f98);
    chk("rst_w_out", w_out, 32'd0);
    chk("rst_w_last", {31'd0, w_last}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_blk_ready", {31'd0, blk_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc_blk[i]  = 32'd0;
      zero_blk[i] = 32'd0;
      ones_blk[i] = 32'hffffffff;
      rnd_blk[i]  = $urandom;
    end
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;

    @(negedge clk);
    do_reset();

    // "abc" with w_ready held high: 64 back-to-back rounds
    build_model(abc_blk);
    load_words(abc_blk, 16, 0);
    drain(1'b0, 1'b0, 64);
    chk("abc_cycles", cycles, 32'd64);
    chk("abc_w0", got_w[0], 32'h61626380);
    chk("abc_w15", got_w[15], 32'h00000018);
    chk("abc_w16", got_w[16], 32'h61626380);
    chk("abc_w17", got_w[17], 32'h000f0000);
    chk("abc_w18", got_w[18], 32'h7da86405);
    chk("abc_w19", got_w[19], 32'h600003c6);
    chk("abc_w63", got_w[63], 32'h12b1edeb);
    after_block();
    save_w = got_w;

    // "abc" with random back-pressure
    load_words(abc_blk, 16, 0);
    drain(1'b1, 1'b0, 64);
    for (int i = 0; i < 64; i++) chk("bp_stream", got_w[i], save_w[i]);
    after_block();

    // gapped load, junk on blk side during RUN, then a clean follow-up block
    build_model(rnd_blk);
    load_words(rnd_blk, 16, 3);
    drain(1'b1, 1'b1, 64);
    after_block();
    build_model(abc_blk);
    load_words(abc_blk, 16, 2);
    drain(1'b1, 1'b0, 64);
    after_block();

    // reset after 7 loaded words
    load_words(abc_blk, 7, 0);
    do_reset();
    load_words(abc_blk, 16, 0);
    drain(1'b0, 1'b0, 64);
    chk("rst_load_w63", got_w[63], 32'h12b1edeb);
    after_block();

    // reset at t=30
    load_words(abc_blk, 16, 0);
    drain(1'b1, 1'b0, 30);
    chk("mid_run_t", {26'd0, t_out}, 32'd30);
    do_reset();
    load_words(abc_blk, 16, 0);
    drain(1'b0, 1'b0, 64);
    chk("rst_run_w63", got_w[63], 32'h12b1edeb);
    after_block();

    // back-to-back: abc then all-zero
    load_words(abc_blk, 16, 0);
    drain(1'b0, 1'b0, 64);
    build_model(zero_blk);
    load_words(zero_blk, 16, 0);
    drain(1'b1, 1'b0, 64);
    chk("zero_w63", got_w[63], 32'd0);
    after_block();

    // all-ones block exercises dropped carries
    build_model(ones_blk);
    load_words(ones_blk, 16, 0);
    drain(1'b0, 1'b0, 64);
    chk("ones_w16_lit", got_w[16], 32'h203ffffc);
    for (int i = 16; i <= 20; i++) chk("ones_w16_20", got_w[i], exp_w[i]);
    after_block();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- SHA-256 message-schedule generator. It is the producer end of the round interface that main_loop consumes.
- Accepts one padded 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
- Emits the 64 round operands (W_t, K_t, t) in order over a valid/ready stream that feeds main_loop's w/k inputs.
- Sits between the padding/block-buffer logic and the compression round.

Parameters:
- None. Widths are fixed by SHA-256: 32-bit words, 64 rounds.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- blk_valid  in  1  blk_word holds a valid message word
- blk_ready  out  1  block accepts a word this cycle
- blk_word  in  32  message word; word 0 (most-significant word of the block) first
- w_valid  out  1  round operands valid
- w_ready  in  1  downstream consumes operands this cycle
- w_out  out  32  W_t
- k_out  out  32  K_t
- t_out  out  6  round index t, 0..63
- w_last  out  1  high with w_valid when t_out==63

Behaviour:
- Handshake: a transfer occurs on a clock edge where valid && ready. Once w_valid rises, w_out, k_out, t_out and w_last stay stable until the transfer. w_valid does not depend combinationally on w_ready.
- State LOAD:
  - blk_ready=1, w_valid=0.
  - Each blk transfer writes window r[cnt] and increments the 4-bit cnt.
  - The transfer with cnt==15 moves to RUN and sets t=0.
- State RUN:
  - blk_ready=0; blk_valid is ignored and no word is lost or consumed.
  - w_valid=1; w_out=r[0]; k_out=K[t]; t_out=t; w_last=(t==63).
- On a w transfer in RUN:
  - Shift r[i]<=r[i+1] for i=0..14.
  - r[15] <= sigma1(r[14]) + r[9] + sigma0(r[1]) + r[0], all modulo 2^32. This is W_{t+16}.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3. sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - t <= t+1.
  - If t==63, return to LOAD with cnt=0. The window contents then become don't-care.
- Latency: w_valid is high on the cycle after the 16th blk transfer, presenting t=0 (W_0 = first word loaded). With w_ready held high, W_0..W_63 are delivered on 64 consecutive cycles. Total block period is 16 load cycles + 64 run cycles.
- Back-pressure:
  - w_ready low holds all state; no update of r or t.
  - blk_valid low in LOAD holds cnt.
- Wrap: t never exceeds 63. cnt wraps 15->0 only together with the LOAD->RUN transition.
- The first blk_ready after the final round is on the cycle following the t==63 transfer. There is no overlap of load and emit.
- Reset (asynchronous, rst==0, any time including mid-block):
  - State=LOAD, cnt=0, t=0, r[*]=0.
  - blk_ready=1 (while rst is deasserted), w_valid=0, w_out=0, k_out=K[0]=428a2f98, t_out=0, w_last=0.
  - A partially loaded or partially emitted block is discarded.
- Deassertion of rst is synchronized by the system; the block assumes the release is clean.

Decomposition:
- Shared package sha256_pkg holds:
  - the 64-entry K constant table (K[0]=428a2f98 ... K[63]=c67178f2);
  - sigma0/sigma1 (and the main-loop SIGMA0/SIGMA1, ch, maj) as functions;
  - the 2-state enum {LOAD, RUN}.
- One sub-module is natural: sha256_sched_next. It is purely combinational and computes W_{t+16} from r[0], r[1], r[9], r[14]. It can be reused by any unrolled scheduler.

Test Plan:
- "abc" padded block (61626380, 14x00000000, 00000018) loaded with w_ready=1. Required sequence:
  - t0: W=61626380, K=428a2f98
  - t15: W=00000018
  - t16: W=61626380
  - t17: W=000f0000
  - t18: W=7da86405
  - t19: W=600003c6
  - t63: W=12b1edeb, K=c67178f2, w_last=1
  - then blk_ready=1 on the next cycle.
- Random w_ready (about 50%) on the "abc" block: the captured W/K/t stream is identical to the previous test. Operands are stable while w_valid && !w_ready. Exactly 64 transfers occur.
- blk_valid toggling during load (gaps of 0–3 cycles), plus blk_valid held high throughout RUN with junk data:
  - no extra words are accepted (blk_ready=0 in RUN);
  - the next block loads correctly after t=63.
- Reset asserted after 7 loaded words, and separately at t=30 in RUN:
  - outputs immediately go to their reset values (w_valid=0, t_out=0, k_out=428a2f98);
  - a fresh "abc" block afterwards yields W_63=12b1edeb.
- Two back-to-back blocks (the "abc" block, then an all-zero block):
  - zero block gives W_t=0 for all t, with k_out following the K table;
  - no cross-contamination from block 1.
- Arithmetic wrap: a block of 16x ffffffff with W_16..W_20 checked against a software model. This confirms the modulo-2^32 sum carries are dropped.
